// File: rtl/cacheline_burst_adaptor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_burst_adaptor_pkg
// Purpose  : Shared definitions for the cache line <-> memory burst adaptor:
//            line/beat geometry, adaptor state encoding, line/beat typedefs
//            and the line-alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cacheline_burst_adaptor_pkg;

  localparam int BEAT_WIDTH   = 64;
  localparam int BEATS        = 4;
  localparam int LINE_WIDTH   = BEAT_WIDTH * BEATS;
  localparam int OFFSET_WIDTH = 5;

  typedef logic [LINE_WIDTH-1:0] cacheline_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adaptor_state_t;

  // Clears the byte-offset-within-line bits so memory always sees the start
  // of the line.
  function automatic logic [31:0] align_line(input logic [31:0] addr);
    return addr & ~((32'd1 << OFFSET_WIDTH) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cacheline_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_burst_adaptor
// Purpose  : Converts 256-bit cache line fill/writeback requests into 4-beat
//            64-bit bursts on the memory port and reassembles read bursts
//            into a full line, finishing with a one-cycle resp_o.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            line_i/line_o   - writeback line in / assembled fill line out
//            address_i       - request address from cache
//            read_i/write_i  - fill / writeback request (sampled in IDLE)
//            resp_o          - one-cycle completion pulse to cache
//            burst_i/burst_o - read beat from / write beat to memory
//            address_o       - line-aligned address to memory
//            read_o/write_o  - burst read / write request to memory
//            resp_i          - beat accepted/valid from memory
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int BEAT_WIDTH = cacheline_burst_adaptor_pkg::BEAT_WIDTH,
  parameter int BEATS      = cacheline_burst_adaptor_pkg::BEATS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BEAT_WIDTH*BEATS-1:0] line_i,
  output logic [BEAT_WIDTH*BEATS-1:0] line_o,
  input  logic [31:0]                 address_i,
  input  logic                        read_i,
  input  logic                        write_i,
  output logic                        resp_o,
  input  logic [BEAT_WIDTH-1:0]       burst_i,
  output logic [BEAT_WIDTH-1:0]       burst_o,
  output logic [31:0]                 address_o,
  output logic                        read_o,
  output logic                        write_o,
  input  logic                        resp_i
);

  localparam int LINE_W = BEAT_WIDTH * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adaptor_state_t    state;
  adaptor_state_t    state_next;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] wbuf;
  logic              last_beat;

  // The final beat is the one taken while the counter sits on the last index.
  assign last_beat = resp_i && (cnt == LAST_BEAT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; writeback wins over fill so dirty data leaves first.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write_i) begin
          state_next = WR_BURST;
        end else if (read_i) begin
          state_next = RD_BURST;
        end
      end
      RD_BURST: if (last_beat) state_next = DONE;
      WR_BURST: if (last_beat) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so they carry no combinational
  // path from the cache-side inputs.
  assign read_o  = (state == RD_BURST);
  assign write_o = (state == WR_BURST);
  assign resp_o  = (state == DONE);

  // Write beat follows the counter directly so memory sees the next beat in
  // the same cycle the previous one is accepted.
  always_comb begin
    burst_o = '0;
    if (state == WR_BURST) begin
      burst_o = wbuf[cnt*BEAT_WIDTH +: BEAT_WIDTH];
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: request latch, beat counter, fill-line assembly
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      line_o    <= '0;
      address_o <= '0;
      wbuf      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            address_o <= align_line(address_i);
            cnt       <= '0;
          end
          if (write_i) begin
            wbuf <= line_i;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_o[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= burst_i;
            cnt <= cnt + 1'b1;
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_burst_adaptor
// Purpose  : Self-checking bench for cacheline_burst_adaptor: table of
//            directed line transactions plus hand-written gapped-burst,
//            stray-resp and asynchronous-reset sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int compared = 0;
  int mismatched = 0;

  // Bench-side record of the last line a read should have delivered.
  logic [255:0] exp_fill = '0;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;      // write line, or beats memory returns on a read
    logic [31:0]  exp_addr;
    logic         exp_wr;    // 1: a write burst is expected
    logic [255:0] exp_line;  // expected line_o (read) / burst_o beats (write)
  } vec_t;

  vec_t vecs[4];

  cacheline_burst_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Runs one request; pat gives resp_i for the first patlen burst cycles,
  // resp_i stays high after that.
  task automatic run_txn(input vec_t v, input logic [15:0] pat, input int patlen);
    int   nbeats;
    int   c;
    logic hold_ok;
    logic [255:0] fill_before;
    fill_before = exp_fill;
    read_i    = v.rd;
    write_i   = v.wr;
    address_i = v.addr;
    line_i    = v.data;
    resp_i    = 1'b0;
    step();
    // Scramble cache-side inputs: the request must already be latched.
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = 32'hA5A5_A5A5;
    line_i    = {4{64'hBADB_ADBA_DBAD_BADB}};
    check("addr_latch", 256'(address_o), 256'(v.exp_addr));
    check("burst_kind_wr", 256'(write_o), 256'(v.exp_wr));
    check("burst_kind_rd", 256'(read_o), 256'(!v.exp_wr));
    nbeats  = 0;
    c       = 0;
    hold_ok = 1'b1;
    while (nbeats < 4 && c < 40) begin
      resp_i  = (c < patlen) ? pat[c] : 1'b1;
      burst_i = resp_i ? v.data[nbeats*64 +: 64] : 64'hFEED_FACE_0BAD_F00D;
      if ((v.exp_wr ? write_o : read_o) !== 1'b1) hold_ok = 1'b0;
      if (resp_o !== 1'b0) hold_ok = 1'b0;
      if (v.exp_wr && resp_i) begin
        check($sformatf("wr_beat%0d", nbeats), 256'(burst_o), 256'(v.exp_line[nbeats*64 +: 64]));
      end
      step();
      if (resp_i) nbeats++;
      c++;
    end
    resp_i  = 1'b0;
    burst_i = '0;
    if (nbeats < 4) begin
      check("beat_timeout", 256'(nbeats), 256'(4));
    end
    check("req_hold", 256'(hold_ok), 256'(1));
    check("done_resp", 256'(resp_o), 256'(1));
    check("done_req_low", 256'({read_o, write_o}), 256'(0));
    check("done_burst_o", 256'(burst_o), 256'(0));
    if (v.exp_wr) begin
      check("line_kept", line_o, fill_before);
    end else begin
      check("fill_line", line_o, v.exp_line);
      exp_fill = v.exp_line;
    end
    step();
    check("resp_single", 256'({resp_o, read_o, write_o}), 256'(0));
  endtask

  initial begin
    vec_t gv;
    vec_t rv;
    logic idle_ok;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                32'h0000_1220, 1'b0,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{1'b0, 1'b1, 32'h8000_003F,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                32'h8000_0020, 1'b1,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}};
    vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFE1,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
                32'hFFFF_FFE0, 1'b1,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_001F,
                {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001},
                32'h0000_0000, 1'b0,
                {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001}};

    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    #2;
    check("rst_ctrl", 256'({read_o, write_o, resp_o}), 256'(0));
    check("rst_data", {line_o[191:0], address_o, burst_o}, 256'(0));
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i], 16'h0000, 0);
    end

    // Gapped read: resp_i 1,0,0,1,1,0,1.
    gv = '{1'b1, 1'b0, 32'h4000_0100,
           {64'h8888_0000_0000_0004, 64'h7777_0000_0000_0003,
            64'h6666_0000_0000_0002, 64'h5555_0000_0000_0001},
           32'h4000_0100, 1'b0,
           {64'h8888_0000_0000_0004, 64'h7777_0000_0000_0003,
            64'h6666_0000_0000_0002, 64'h5555_0000_0000_0001}};
    run_txn(gv, 16'b0000_0000_0101_1001, 7);

    // Stray resp_i while idle must not move anything.
    idle_ok = 1'b1;
    resp_i  = 1'b1;
    burst_i = 64'h9999_9999_9999_9999;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({read_o, write_o, resp_o} !== 3'b000) idle_ok = 1'b0;
      if (line_o !== exp_fill) idle_ok = 1'b0;
    end
    resp_i = 1'b0;
    check("stray_resp_idle", 256'(idle_ok), 256'(1));
    check("stray_line_kept", line_o, exp_fill);

    // Async reset after two beats of a read.
    read_i    = 1'b1;
    address_i = 32'h2000_0040;
    step();
    read_i  = 1'b0;
    resp_i  = 1'b1;
    burst_i = 64'hAAAA_0000_0000_0000;
    step();
    burst_i = 64'hBBBB_0000_0000_0000;
    step();
    resp_i = 1'b0;
    check("pre_rst_read_o", 256'(read_o), 256'(1));
    #1 rst = 1'b1;
    #1;
    check("async_rst_ctrl", 256'({read_o, write_o, resp_o}), 256'(0));
    check("async_rst_data", {line_o[191:0], address_o, burst_o}, 256'(0));
    #1 rst = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({read_o, write_o, resp_o} !== 3'b000) idle_ok = 1'b0;
    end
    check("no_resp_after_abort", 256'(idle_ok), 256'(1));
    exp_fill = '0;

    rv = '{1'b1, 1'b0, 32'h2000_0047,
           {64'h0000_0000_CAFE_0004, 64'h0000_0000_CAFE_0003,
            64'h0000_0000_CAFE_0002, 64'h0000_0000_CAFE_0001},
           32'h2000_0040, 1'b0,
           {64'h0000_0000_CAFE_0004, 64'h0000_0000_CAFE_0003,
            64'h0000_0000_CAFE_0002, 64'h0000_0000_CAFE_0001}};
    run_txn(rv, 16'h0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Memory-side end of the pipelined cache's line interface.
- Takes 256-bit line fill and writeback requests from the cache datapath/control and turns them into 4-beat, 64-bit bursts on the physical-memory port.
- Reassembles read bursts into a 256-bit line and returns a single-cycle completion to the cache.
- Sits between pipelined cache control/regs and the memory model or arbiter.

Parameters:
- BEAT_WIDTH, 64, data bits per burst beat
- BEATS, 4, beats per cache line; LINE_WIDTH = BEAT_WIDTH*BEATS = 256

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- line_i  in  256  writeback line from cache
- line_o  out  256  assembled fill line to cache
- address_i  in  32  request address from cache
- read_i  in  1  line fill request
- write_i  in  1  line writeback request
- resp_o  out  1  one-cycle completion pulse to cache
- burst_i  in  64  read beat from memory
- burst_o  out  64  write beat to memory
- address_o  out  32  line-aligned address to memory
- read_o  out  1  burst read request to memory
- write_o  out  1  burst write request to memory
- resp_i  in  1  beat accepted/valid from memory

Behaviour:
- Reset (async, active-high):
  - State = IDLE and beat count = 0.
  - line_o, address_o, and the write buffer are cleared to 0.
  - read_o, write_o, and resp_o are 0; burst_o = 0.
  - Reset asserted mid-burst aborts the transfer immediately. No resp_o is produced for the aborted request.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - read_i/write_i are sampled here only.
  - write_i has priority if both are high (writeback precedes fill).
  - On accept, latch address_o = {address_i[31:5], 5'b0}. Write requests also latch line_i into the write buffer.
  - Clear the beat count, then go to RD_BURST or WR_BURST.
  - resp_i in IDLE is ignored.
- RD_BURST:
  - read_o = 1 until the last beat is taken.
  - On each cycle with resp_i = 1, burst_i is stored into line_o[64*cnt +: 64] and cnt increments.
  - Gaps (resp_i = 0) pause the count; no timeout.
  - The beat with cnt = 3 and resp_i = 1 transitions to DONE. read_o is 0 from that next cycle.
- WR_BURST:
  - write_o = 1; burst_o = buffer[64*cnt +: 64], combinational from cnt.
  - Each cycle with resp_i = 1 consumes the current beat and cnt increments.
  - The beat with cnt = 3 and resp_i = 1 transitions to DONE.
- DONE:
  - resp_o = 1 for exactly one cycle; read_o = write_o = 0.
  - line_o holds the complete line (read) and stays stable until the next read burst's first beat.
  - Next state is IDLE.
- Turnaround: a new request is accepted in the IDLE cycle following DONE. The requester must deassert read_i/write_i in the cycle after it sees resp_o, otherwise a repeat transfer starts.
- Beat count: 2 bits, wraps 3->0 only on burst completion. Byte order is little-endian by beat (beat 0 = bits 63:0).
- Latency:
  - Minimum request-to-resp_o is 1 (accept) + 4 (beats) + 1 (DONE) = 6 cycles.
  - Memory may first assert resp_i in the cycle after read_o/write_o rise.
- address_o, read_o, write_o, and resp_o are driven only from registers/state, with no combinational path from cache inputs.
- burst_o and line_o are don't-care to the cache except as specified above. burst_o = 0 outside WR_BURST.

Decomposition:
- Shared cache package holds:
  - LINE_WIDTH, BEAT_WIDTH, BEATS, and the line offset width (5).
  - The adaptor state enum (IDLE, RD_BURST, WR_BURST, DONE).
  - Typedefs cacheline_t (256) and beat_t (64).
- Single module; the beat counter and line buffer are inline, and no sub-module is warranted.

Test Plan:
- Read, back-to-back beats:
  - Stimulus: read_i with address_i = 0x0000_1234; memory returns resp_i 4 cycles with beats 0x1111..., 0x2222..., 0x3333..., 0x4444....
  - Required: address_o = 0x0000_1220, resp_o pulse 1 cycle after the last beat, line_o = {0x4444...,0x3333...,0x2222...,0x1111...}.
- Write:
  - Stimulus: write_i with line_i = 256'hDDDD_CCCC_BBBB_AAAA pattern (64-bit lanes A, B, C, D).
  - Required: burst_o presents A, B, C, D on successive resp_i cycles; write_o drops and resp_o pulses after the 4th beat.
- Gapped burst:
  - Stimulus: read with resp_i pattern 1,0,0,1,1,0,1.
  - Required: exactly 4 beats captured in order, resp_o once, read_o held high through the gaps.
- Simultaneous request:
  - Stimulus: read_i = write_i = 1 in IDLE.
  - Required: a write burst occurs first (write_o = 1, read_o = 0).
- Async reset mid-burst:
  - Stimulus: rst pulse between clock edges after beat 2 of a read.
  - Required: outputs go to 0 immediately without a clock edge, no resp_o, and the next read completes normally with cnt restarting at 0.
- Stray resp_i:
  - Stimulus: resp_i = 1 while IDLE.
  - Required: no state change, line_o unchanged, resp_o = 0.
